reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   8-entry x 32-bit architectural register file for the x86-style integer datapath (EAX..EDI).
//   Two combinational read ports and one synchronous write port.
//   Read by decode/operand fetch; written by writeback.
// PARAMETERS
//   DATA_W    32            register width in bits
//   NUM_REGS  8             number of registers; must equal 2**IDX_W
//   IDX_W     3             index width for src1_idx, src2_idx and dst_idx
//   SET_VAL   32'hFFFF_FFFF value loaded into every register while set is asserted
// PORTS
//   clk           in   1       single clock; all writes occur on the rising edge
//   rst           in   1       asynchronous, active-high reset
//   set           in   1       asynchronous, active-high preset
//   we            in   1       write enable, sampled on the rising edge of clk
//   src1_idx      in   IDX_W   read port 1 register index
//   src2_idx      in   IDX_W   read port 2 register index
//   dst_idx       in   IDX_W   write register index
//   w_val         in   DATA_W  write data
//   regfile_out1  out  DATA_W  contents of register[src1_idx]
//   regfile_out2  out  DATA_W  contents of register[src2_idx]
// BEHAVIOUR
//   - Reset: while rst=1, all registers are 0 immediately, with no clock needed.
//     Outputs therefore read 0 for every index.
//   - Set: while set=1 and rst=0, all registers equal SET_VAL asynchronously.
//   - Priority: rst > set > write.
//   - Write: on posedge clk with rst=0, set=0 and we=1, register[dst_idx] <= w_val.
//     No other register changes.
//   - we=0: no register changes, regardless of dst_idx or w_val.
//   - Read: purely combinational, zero latency.
//     regfile_out1 = register[src1_idx]; regfile_out2 = register[src2_idx].
//     Outputs update within the same delta cycle when an index or register changes.
//   - Both ports may address the same register; both return the same value.
//   - Read-during-write (same index): outputs show the OLD value until the clock edge.
//     They show the new value immediately after the edge, unless REG_FILE_BYPASS_EN is defined.
//   - Deasserting rst or set mid-cycle: registers hold their reset/preset values until the next qualifying write.
//   - Index map: 0 EAX, 1 ECX, 2 EDX, 3 EBX, 4 ESP, 5 EBP, 6 ESI, 7 EDI.
//     All 8 indices are valid; there is no out-of-range case.
//   - No X propagation out of reset: every register has a defined value after rst.
// CONFIGURATION
//   REG_FILE_BYPASS_EN
//     defined: when we=1 and srcN_idx==dst_idx (rst=0, set=0), regfile_outN = w_val combinationally (write-through forwarding).
//       Applied independently per read port.
//     undefined: no forwarding; reads always return stored register contents.
// STRUCTURE
//   - Package reg_file_pkg holds DATA_W/IDX_W defaults and localparams EAX=3'd0 .. EDI=3'd7.
//     It also holds typedef reg_idx_t (logic [IDX_W-1:0]) and typedef reg_data_t (logic [DATA_W-1:0]).
//   - Sub-module reg_file_rd_port is instantiated twice.
//     It provides the NUM_REGS:1 read mux plus optional bypass compare.
//   - Storage is an array of NUM_REGS flops with one-hot decoded write enables from dst_idx and we.
// TESTING
//   1. rst=1, src1=0, src2=1 -> out1=0, out2=0 without any clk edge. Release rst.
//   2. dst=0, w_val=DEADBEEF, we=1, one posedge; then we=0, src1=0, src2=1 -> out1=DEADBEEF, out2=00000000.
//   3. dst=1, w_val=CAFEBABE, we=1, one posedge -> out1(EAX)=DEADBEEF, out2(ECX)=CAFEBABE.
//   4. src1=src2=1 -> out1=out2=CAFEBABE.
//   5. we=0, dst=0, w_val=BADF00D5, one posedge -> EAX still DEADBEEF, ECX still CAFEBABE.
//   6. set=1 -> all 8 regs read FFFFFFFF; assert rst with set still 1 -> all read 0.
//      With REG_FILE_BYPASS_EN defined: we=1, dst=src1=3, w_val=12345678 -> out1=12345678 before the posedge.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths, x86 register index names and types for reg_file.
package reg_file_pkg;
    localparam int REG_DATA_W = 32;
    localparam int REG_IDX_W = 3;
    localparam int REG_NUM = 8;
    localparam logic [REG_DATA_W-1:0] REG_SET_VAL = 32'hFFFF_FFFF;
    localparam logic [REG_IDX_W-1:0] EAX = 3'd0;
    localparam logic [REG_IDX_W-1:0] ECX = 3'd1;
    localparam logic [REG_IDX_W-1:0] EDX = 3'd2;
    localparam logic [REG_IDX_W-1:0] EBX = 3'd3;
    localparam logic [REG_IDX_W-1:0] ESP = 3'd4;
    localparam logic [REG_IDX_W-1:0] EBP = 3'd5;
    localparam logic [REG_IDX_W-1:0] ESI = 3'd6;
    localparam logic [REG_IDX_W-1:0] EDI = 3'd7;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: NUM_REGS:1 read mux; with REG_FILE_BYPASS_EN defined,
// forwards the in-flight write data when the read index matches the write index.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int IDX_W = REG_IDX_W,
    parameter int NUM_REGS = REG_NUM
) (
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    input  logic [IDX_W-1:0]  idx,
`ifdef REG_FILE_BYPASS_EN
    input  logic              fwd_en,
    input  logic [IDX_W-1:0]  dst_idx,
    input  logic [DATA_W-1:0] w_val,
`endif
    output logic [DATA_W-1:0] rd_val
);
    always_comb begin
`ifdef REG_FILE_BYPASS_EN
        rd_val = (fwd_en && idx == dst_idx) ? w_val : regs[idx];
`else
        rd_val = regs[idx];
`endif
    end
endmodule

// File: rtl/reg_file.sv
// reg_file: 8x32 x86 register file, two combinational reads, one clocked write,
// async reset/preset (rst > set > write). Optional write-through via REG_FILE_BYPASS_EN.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int NUM_REGS = REG_NUM,
    parameter int IDX_W = REG_IDX_W,
    parameter logic [DATA_W-1:0] SET_VAL = REG_SET_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic              we,
    input  logic [IDX_W-1:0]  src1_idx,
    input  logic [IDX_W-1:0]  src2_idx,
    input  logic [IDX_W-1:0]  dst_idx,
    input  logic [DATA_W-1:0] w_val,
    output logic [DATA_W-1:0] regfile_out1,
    output logic [DATA_W-1:0] regfile_out2
);
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_en;

    always_comb begin
        wr_en = '0;
        wr_en[dst_idx] = we;
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = wr_en[i] ? w_val : regs_q[i];
    end

    always_ff @(posedge clk or posedge rst or posedge set) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (set) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= SET_VAL;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // Forwarding is suppressed while reset or preset own the array.
    logic fwd_en;
    assign fwd_en = we && !rst && !set;
`endif

    reg_file_rd_port #(.DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_rd1 (
        .regs    (regs_q),
        .idx     (src1_idx),
`ifdef REG_FILE_BYPASS_EN
        .fwd_en  (fwd_en),
        .dst_idx (dst_idx),
        .w_val   (w_val),
`endif
        .rd_val  (regfile_out1)
    );

    reg_file_rd_port #(.DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_rd2 (
        .regs    (regs_q),
        .idx     (src2_idx),
`ifdef REG_FILE_BYPASS_EN
        .fwd_en  (fwd_en),
        .dst_idx (dst_idx),
        .w_val   (w_val),
`endif
        .rd_val  (regfile_out2)
    );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed stimulus with a queued scoreboard checked by a separate monitor.
module tb_reg_file;
    import reg_file_pkg::*;

    typedef struct {
        string     name;
        reg_data_t e1;
        reg_data_t e2;
    } exp_t;

    logic      clk = 1'b0, clk_en = 1'b0;
    logic      rst = 1'b0, set = 1'b0, we = 1'b0;
    reg_idx_t  src1_idx = '0, src2_idx = '0, dst_idx = '0;
    reg_data_t w_val = '0;
    reg_data_t regfile_out1, regfile_out2;

    exp_t      sb_q[$];
    event      smp;
    int        total = 0, bad = 0;
    reg_data_t model [8];
    reg_idx_t  names [8];

    reg_file dut (
        .clk(clk), .rst(rst), .set(set), .we(we),
        .src1_idx(src1_idx), .src2_idx(src2_idx), .dst_idx(dst_idx), .w_val(w_val),
        .regfile_out1(regfile_out1), .regfile_out2(regfile_out2)
    );

    always #5 if (clk_en) clk = ~clk;

    initial forever begin
        @(smp);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            total += 2;
            if (regfile_out1 !== e.e1) begin
                bad++;
                $display("FAIL %s out1: got %h expected %h", e.name, regfile_out1, e.e1);
            end
            if (regfile_out2 !== e.e2) begin
                bad++;
                $display("FAIL %s out2: got %h expected %h", e.name, regfile_out2, e.e2);
            end
        end
    end

    task automatic chk(input string n, input reg_data_t e1, input reg_data_t e2);
        sb_q.push_back('{name: n, e1: e1, e2: e2});
        ->smp;
        #1;
    endtask

    task automatic rd(input string n, input reg_idx_t a, input reg_idx_t b, input reg_data_t e1, input reg_data_t e2);
        src1_idx = a;
        src2_idx = b;
        #1;
        chk(n, e1, e2);
    endtask

    task automatic wr(input reg_idx_t idx, input reg_data_t val);
        @(negedge clk);
        dst_idx = idx;
        w_val = val;
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic sweep(input string n);
        for (int i = 0; i < 8; i++) rd(n, names[i], names[7-i], model[i], model[7-i]);
    endtask

    initial begin
        names = '{EAX, ECX, EDX, EBX, ESP, EBP, ESI, EDI};
        for (int i = 0; i < 8; i++) model[i] = '0;
        #1 rst = 1'b1;
        rd("reset_no_clk", EAX, ECX, 32'h0, 32'h0);
        sweep("reset_sweep");
        rst = 1'b0;
        clk_en = 1'b1;

        wr(EAX, 32'hDEAD_BEEF);
        rd("write_eax", EAX, ECX, 32'hDEAD_BEEF, 32'h0);

        @(negedge clk);
        dst_idx = ECX; w_val = 32'hCAFE_BABE; we = 1'b1;
        src1_idx = EAX; src2_idx = ECX;
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("rdw_before_edge", 32'hDEAD_BEEF, 32'hCAFE_BABE);
`else
        chk("rdw_before_edge", 32'hDEAD_BEEF, 32'h0);
`endif
        @(posedge clk);
        #1;
        we = 1'b0;
        chk("write_ecx", 32'hDEAD_BEEF, 32'hCAFE_BABE);
        rd("same_index", ECX, ECX, 32'hCAFE_BABE, 32'hCAFE_BABE);

        @(negedge clk);
        dst_idx = EAX; w_val = 32'hBADF_00D5; we = 1'b0;
        @(posedge clk);
        #1;
        rd("we0_hold", EAX, ECX, 32'hDEAD_BEEF, 32'hCAFE_BABE);

        model[0] = 32'hDEAD_BEEF;
        model[1] = 32'hCAFE_BABE;
        wr(EDX, 32'h2222_0002); model[2] = 32'h2222_0002;
        wr(EBX, 32'h3333_0003); model[3] = 32'h3333_0003;
        wr(ESP, 32'h4444_0004); model[4] = 32'h4444_0004;
        wr(EBP, 32'h5555_0005); model[5] = 32'h5555_0005;
        wr(ESI, 32'h6666_0006); model[6] = 32'h6666_0006;
        wr(EDI, 32'h7777_0007); model[7] = 32'h7777_0007;
        sweep("decode_sweep");
        wr(EBX, 32'h0000_0000); model[3] = 32'h0;
        sweep("overwrite_sweep");

        @(negedge clk);
        set = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 32'hFFFF_FFFF;
        #1;
        sweep("set_sweep");
        wr(EDX, 32'h1234_0000);
        rd("set_blocks_write", EDX, EAX, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = '0;
        #1;
        sweep("rst_over_set");
        @(negedge clk);
        rst = 1'b0;
        set = 1'b0;
        @(posedge clk);
        #1;
        sweep("released_hold");

        wr(EBP, 32'hA5A5_5A5A); model[5] = 32'hA5A5_5A5A;
        rd("write_after_rst", EBP, ESI, 32'hA5A5_5A5A, 32'h0);

`ifdef REG_FILE_BYPASS_EN
        @(negedge clk);
        dst_idx = EBX; w_val = 32'h1234_5678; we = 1'b1;
        src1_idx = EBX; src2_idx = EBP;
        #1;
        chk("bypass_fwd", 32'h1234_5678, 32'hA5A5_5A5A);
        @(posedge clk);
        #1;
        we = 1'b0;
        chk("bypass_after_edge", 32'h1234_5678, 32'hA5A5_5A5A);
`endif

        for (int k = 0; k < 100 && sb_q.size() != 0; k++) #1;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
